// File: rtl/mlp_argmax.sv
// Argmax stage for the MLP output vector: captures scores, scans one per cycle, hands off result.
// Optional second-max/margin logic is built when MLP_ARGMAX_MARGIN_EN is defined.
module mlp_argmax #(
   parameter int unsigned OUTPUT_WIDTH = 20,
   parameter int unsigned NUM_OUTPUTS  = 3,
   parameter int unsigned IDX_WIDTH    = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   input  logic [OUTPUT_WIDTH*NUM_OUTPUTS-1:0] in_data,
   output logic                                in_ready,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [IDX_WIDTH-1:0]                out_idx,
   output logic [OUTPUT_WIDTH-1:0]             out_max,
   output logic [OUTPUT_WIDTH-1:0]             out_margin,
   output logic                                drop_err
);

   typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

   state_e                              state_q;
   logic [OUTPUT_WIDTH*NUM_OUTPUTS-1:0] buf_q;
   logic [OUTPUT_WIDTH-1:0]             best_q;
   logic [IDX_WIDTH-1:0]                idx_q;
   logic [IDX_WIDTH-1:0]                cnt_q;

   logic [OUTPUT_WIDTH-1:0]             elem;
   logic                                gt_best;
   logic                                last;
   logic [OUTPUT_WIDTH-1:0]             nxt_best;
   logic [IDX_WIDTH-1:0]                nxt_idx;

   assign in_ready = (state_q == StIdle);
   assign last     = (cnt_q == IDX_WIDTH'(NUM_OUTPUTS - 1));

   always_comb begin
      elem = '0;
      for (int i = 0; i < int'(NUM_OUTPUTS); i++) begin
         if (cnt_q == IDX_WIDTH'(i)) elem = buf_q[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      end
      // Strict greater-than: ties keep the lower index.
      gt_best  = $signed(elem) > $signed(best_q);
      nxt_best = gt_best ? elem : best_q;
      nxt_idx  = gt_best ? cnt_q : idx_q;
   end

`ifdef MLP_ARGMAX_MARGIN_EN
   logic [OUTPUT_WIDTH-1:0] second_q;
   logic [OUTPUT_WIDTH-1:0] margin_q;
   logic [OUTPUT_WIDTH-1:0] nxt_second;
   logic [OUTPUT_WIDTH:0]   diff;
   logic [OUTPUT_WIDTH-1:0] nxt_margin;

   always_comb begin
      if (gt_best) begin
         nxt_second = best_q;
      end else if ($signed(elem) > $signed(second_q)) begin
         nxt_second = elem;
      end else begin
         nxt_second = second_q;
      end
      diff = {nxt_best[OUTPUT_WIDTH-1], nxt_best} - {nxt_second[OUTPUT_WIDTH-1], nxt_second};
      // diff is never negative, so any of the top two bits set means it exceeds the max positive.
      if (diff[OUTPUT_WIDTH] || diff[OUTPUT_WIDTH-1]) begin
         nxt_margin = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
      end else begin
         nxt_margin = diff[OUTPUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         second_q <= '0;
         margin_q <= '0;
      end else begin
         if (state_q == StIdle && in_valid) begin
            second_q <= {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
         end else if (state_q == StScan) begin
            second_q <= nxt_second;
            if (last) margin_q <= nxt_margin;
         end
      end
   end

   assign out_margin = margin_q;
`else
   assign out_margin = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         buf_q     <= '0;
         best_q    <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_max   <= '0;
         drop_err  <= 1'b0;
      end else begin
         if (in_valid && state_q != StIdle) drop_err <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  buf_q   <= in_data;
                  best_q  <= in_data[OUTPUT_WIDTH-1:0];
                  idx_q   <= '0;
                  cnt_q   <= IDX_WIDTH'(1);
                  state_q <= StScan;
               end
            end
            StScan: begin
               best_q <= nxt_best;
               idx_q  <= nxt_idx;
               cnt_q  <= cnt_q + IDX_WIDTH'(1);
               if (last) begin
                  out_idx   <= nxt_idx;
                  out_max   <= nxt_best;
                  out_valid <= 1'b1;
                  state_q   <= StHold;
               end
            end
            StHold: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/mlp_argmax.md
# mlp_argmax

Output-classification stage that sits directly downstream of `cordic_mlp`. It captures the flattened output vector on each `mlp_valid` pulse and scans the signed scores sequentially, one per cycle. It then presents the winning class index, the winning score and an optional confidence margin through a valid/ready handshake to the host or readout logic. Scores arriving while a previous result is still in flight are dropped and flagged.

## Interface
- `OUTPUT_WIDTH`, 20: width of each signed score (two's complement, same format as the MLP output).
- `NUM_OUTPUTS`, 3: number of scores per vector; must be >= 2.
- `IDX_WIDTH`, 2: width of the class index; must be >= ceil(log2(NUM_OUTPUTS)).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  one-cycle pulse, wired to `mlp_valid`.
- `in_data`  in  OUTPUT_WIDTH*NUM_OUTPUTS  score vector; element i is in bits [(i+1)*OUTPUT_WIDTH-1 : i*OUTPUT_WIDTH].
- `in_ready`  out  1  high only in IDLE; combinational from state.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_idx`  out  IDX_WIDTH  index of the maximum score.
- `out_max`  out  OUTPUT_WIDTH  maximum score, signed.
- `out_margin`  out  OUTPUT_WIDTH  max minus second max, non-negative, saturated.
- `drop_err`  out  1  sticky flag: a vector was lost; cleared only by reset.

## Operation
The block is a three-state FSM: IDLE, SCAN, HOLD.

- **IDLE**
  - `in_ready`=1.
  - When `in_valid`=1: latch `in_data` into an internal buffer; best=e0, idx=0, second=most-negative value, cnt=1; go to SCAN.
- **SCAN**
  - Each cycle, compare element e[cnt] using a signed comparison, then increment cnt.
  - If e > best: second=best, best=e, idx=cnt.
  - Else if e > second: second=e.
  - Ties keep the lower index: equality does not replace best.
  - The compare with cnt==NUM_OUTPUTS-1 registers the outputs and goes to HOLD.
- **HOLD**
  - `out_valid`=1; `out_idx`, `out_max` and `out_margin` stay stable.
  - `out_valid` && `out_ready` returns to IDLE.
- **Margin arithmetic**
  - Difference is computed at OUTPUT_WIDTH+1 bits.
  - Result is saturated to 2^(OUTPUT_WIDTH-1)-1.
- **Dropped input:** `in_valid` in SCAN or HOLD is ignored, the captured buffer is untouched, and `drop_err` is set the next edge. This includes the HOLD cycle in which `out_ready`=1.
- **Output values outside HOLD:** hold their last result; they are zero after reset.

## Timing
- **Reset values:** all outputs are 0 except `in_ready`=1 (state IDLE). This applies asynchronously while `rst_n`=0.
- **Latency:** capture at edge k; `out_valid` rises after edge k+NUM_OUTPUTS-1 (edge k+2 for the default).
- **Earliest next capture:** `in_ready` rises the cycle after the handshake edge, so the first new vector can be taken at edge h+1.
- **Throughput:** at most one vector per NUM_OUTPUTS+1 cycles with `out_ready` held high.
- **Reset mid-SCAN or mid-HOLD:** aborts the result; no `out_valid` is produced for the vector.
- **MLP rate:** `cordic_mlp` takes hundreds of cycles per inference, so drops only occur under sustained consumer backpressure.

## Configuration
- `MLP_ARGMAX_MARGIN_EN` defined:
  - second-max register and subtract/saturate logic are built;
  - `out_margin` behaves as above.
- Undefined:
  - no second-max tracking;
  - `out_margin` is tied to 0;
  - `out_idx`, `out_max`, timing and handshake are unchanged.

## Test plan
- **Basic scan.** Stimulus: e0=10000, e1=20000, e2=30000 (hex), pulse `in_valid`, `out_ready`=1.
  - `out_valid` is asserted 2 edges after capture.
  - `out_idx`=2, `out_max`=30000, `out_margin`=10000.
- **Signed compare.** Stimulus: e0=FFFF0, e1=FFF00, e2=80000.
  - `out_idx`=0, `out_max`=FFFF0, `out_margin`=000F0.
- **Tie.** Stimulus: e0=20000, e1=20000, e2=10000.
  - `out_idx`=0, `out_margin`=0.
- **Backpressure and drop.** Stimulus: hold `out_ready`=0 for 5 cycles in HOLD and pulse `in_valid` with a new vector.
  - Outputs stay unchanged and `drop_err`=1.
  - After the handshake, `in_ready`=1.
  - The next vector is processed correctly.
- **Margin saturation.** Stimulus: e0=7FFFF, e1=80000, e2=80000.
  - `out_idx`=0, `out_margin`=7FFFF.
  - Without the macro, `out_margin`=0.
- **Reset mid-SCAN.** Stimulus: drop `rst_n` one cycle after capture.
  - `out_valid`=0, `drop_err`=0, `in_ready`=1 after release.
  - A new vector then completes with correct values.
